decode_write_fifo: RTL and testbench
====================================

Name: decode_write_fifo

Overview:
- Buffer between the DECODE stage (producer) and the WRITE stage (consumer) of the pipelined CPU.
- DECODE pushes one complex word per cycle with data_write and complex_data.
- WRITE pops one word per cycle with data_read and DAO.
- Generates the stall signals pause_DECODE (buffer full) and pause_WRITE (buffer empty) that the pipelined control consumes.

Parameters:
- DATA_W, 14, data field width.
- ADDR_W, 12, address field width.
- DEPTH, 8, number of entries; power of two, 2..64.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_write  in  1  push request from DECODE.
- complex_data  in  DATA_W+ADDR_W+4  pushed word: [top 4] opcode, [next ADDR_W] address, [low DATA_W] data.
- data_read  in  1  pop request from WRITE.
- DAO  out  DATA_W+ADDR_W+4  head entry (first-word-fall-through).
- pause_DECODE  out  1  buffer full; DECODE must hold.
- pause_WRITE  out  1  buffer empty; DAO is invalid.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push was rejected.
- underflow  out  1  sticky: pop was rejected.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, DAO=0, pause_WRITE=1, pause_DECODE=0. Storage contents are don't-care.
- push_ok = data_write & (count<DEPTH | data_read). A push on full is accepted only if a pop occurs in the same cycle.
- pop_ok = data_read & (count!=0). A pop on empty is never accepted, even with a simultaneous push; that push is still accepted.
- Accepted push: mem[wr_ptr]<=complex_data; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Accepted pop: rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push only: count+1
  - pop only: count-1
  - both or neither: unchanged
- Rejected push (data_write & !push_ok): overflow<=1. It clears only on reset.
- Rejected pop (data_read & count==0): underflow<=1. It clears only on reset.
- DAO = mem[rd_ptr] (combinational read of registered storage), forced to 0 when count==0.
- Latency: a push into an empty buffer in cycle N makes DAO valid and drops pause_WRITE in cycle N+1. No bypass within the same cycle.
- pause_DECODE = (count==DEPTH); pause_WRITE = (count==0). Both are decoded from registered count.
- Simultaneous push and pop with 0<count<DEPTH: both proceed, count is unchanged, and FIFO ordering is preserved.
- Reset asserted mid-operation: all state returns to reset values immediately. Queued words are lost, with no partial pop.
- Unknown (X) data_write or data_read is a protocol violation and is not handled.

Decomposition:
- Package cpu_pipe_pkg holds:
  - field width constants: OPC_W=4, DATA_W, ADDR_W
  - CPLX_W = DATA_W+ADDR_W+4
  - field slice offsets OPC_LSB and ADDR_LSB, shared with DECODE and WRITE
- Sub-module fifo_regfile: DEPTH x CPLX_W register array with one synchronous write port and one asynchronous read port, no reset on storage.
- Pointer, count and flag logic live in decode_write_fifo.

Test Plan:
- Reset, then push 0x0ABC_1234 once -> next cycle DAO=0x0ABC_1234, count=1, pause_WRITE=0; pop -> count=0, pause_WRITE=1, DAO=0.
- Push 8 sequential words 1..8 with no pops -> count=8, pause_DECODE=1 after the 8th; 9th push alone -> overflow=1, count stays 8; pop 8 times -> DAO reads 1..8 in order.
- Full buffer, assert data_write and data_read together with word 0x55 -> push accepted, count stays 8, overflow stays 0, 0x55 emerges last.
- Empty buffer, assert data_write (0x77) and data_read together -> underflow=1, count=1, DAO=0x77 next cycle.
- Push/pop continuously for 20 cycles, exceeding DEPTH twice -> pointers wrap, output order equals input order, count constant at 1.
- Fill to 5 entries, drop reset to 0 asynchronously between clock edges -> count=0, pause_WRITE=1, DAO=0 immediately; flags cleared.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared field layout of the complex word passed from DECODE to WRITE.
// Widths and slice offsets used by both stages and the buffer between them.
package cpu_pipe_pkg;

  localparam int OPC_W  = 4;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;
  localparam int CPLX_W = DATA_W + ADDR_W + OPC_W;

  localparam int ADDR_LSB = DATA_W;
  localparam int OPC_LSB  = DATA_W + ADDR_W;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for decode_write_fifo: one synchronous write port,
// one asynchronous read port, no reset on the contents.
module fifo_regfile #(
  parameter int W     = cpu_pipe_pkg::CPLX_W,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_write_fifo.sv
// DECODE -> WRITE buffer: first-word-fall-through FIFO that raises
// pause_DECODE when full and pause_WRITE when empty.
module decode_write_fifo #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W,
  parameter int ADDR_W = cpu_pipe_pkg::ADDR_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_write,
  input  logic [DATA_W+ADDR_W+3:0] complex_data,
  input  logic                     data_read,
  output logic [DATA_W+ADDR_W+3:0] DAO,
  output logic                     pause_DECODE,
  output logic                     pause_WRITE,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int W     = DATA_W + ADDR_W + cpu_pipe_pkg::OPC_W;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [W-1:0]     head;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign push_ok = data_write & (~full | data_read);
  assign pop_ok  = data_read & ~empty;

  fifo_regfile #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (complex_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (data_write & ~push_ok) overflow  <= 1'b1;
      if (data_read & empty)     underflow <= 1'b1;
    end
  end

  assign DAO          = empty ? '0 : head;
  assign pause_DECODE = full;
  assign pause_WRITE  = empty;

endmodule

// File: tb/tb_decode_write_fifo.sv
// Directed bench for decode_write_fifo: vector table plus
// hand-written wrap, simultaneous push/pop and async reset sequences.
module tb_decode_write_fifo;

  localparam int W = 30;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;
    logic [W-1:0] dao;
    logic         pd;
    logic         pw;
    logic         ovf;
    logic         udf;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         data_write = 1'b0;
  logic         data_read = 1'b0;
  logic [W-1:0] complex_data = '0;
  logic [W-1:0] dao;
  logic         pause_decode;
  logic         pause_write;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;

  int passed = 0;
  int total  = 0;

  vec_t vecs[$];
  logic [W-1:0] model[$];

  decode_write_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .complex_data (complex_data),
    .data_read    (data_read),
    .DAO          (dao),
    .pause_DECODE (pause_decode),
    .pause_WRITE  (pause_write),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [W-1:0] d);
    data_write   = wr;
    data_read    = rd;
    complex_data = d;
    @(posedge clk);
    #1;
    data_write = 1'b0;
    data_read  = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int cnt,
                         input logic [W-1:0] d, input logic pd,
                         input logic pw, input logic ovf, input logic udf);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".dao"}, 32'(dao), 32'(d));
    chk({tag, ".pause_decode"}, 32'(pause_decode), 32'(pd));
    chk({tag, ".pause_write"}, 32'(pause_write), 32'(pw));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(udf));
  endtask

  function automatic vec_t mk(logic wr, logic rd, logic [W-1:0] din, int cnt,
                              logic [W-1:0] d, logic pd, logic pw,
                              logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.dao = d;
    v.pd = pd; v.pw = pw; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic do_reset();
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back(mk(1, 0, 30'h0ABC_1234, 1, 30'h0ABC_1234, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 30'h0, 0, 30'h0, 0, 1, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 0, W'(i), i, 30'h1, i == 8, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h9, 8, 30'h1, 1, 0, 1, 0));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0, 1, 30'h0, 8 - j, j < 8 ? W'(j + 1) : '0,
                        0, j == 8, 1, 0));

    #12 reset = 1'b1;
    @(negedge clk);
    chk_all("reset", 0, '0, 0, 1, 0, 0);

    foreach (vecs[k]) begin
      cyc(vecs[k].wr, vecs[k].rd, vecs[k].din);
      chk_all($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].dao,
              vecs[k].pd, vecs[k].pw, vecs[k].ovf, vecs[k].udf);
    end

    // Full buffer: push and pop together.
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 0, W'(i));
    chk("full.count", 32'(count), 32'd8);
    cyc(1, 1, 30'h55);
    chk_all("full_pp", 8, 30'h2, 1, 0, 0, 0);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("full_drain%0d", i), 32'(dao),
          i == 9 ? 32'h55 : 32'(i));
      cyc(0, 1, '0);
    end
    chk_all("full_empty", 0, '0, 0, 1, 0, 0);

    // Empty buffer: push and pop together.
    do_reset();
    cyc(1, 1, 30'h77);
    chk_all("empty_pp", 1, 30'h77, 0, 0, 0, 1);

    // Continuous push/pop with one entry in flight, wrapping twice.
    model.delete();
    model.push_back(30'h77);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wrap_head%0d", i), 32'(dao), 32'(model[0]));
      cyc(1, 1, W'(100 + i));
      void'(model.pop_front());
      model.push_back(W'(100 + i));
      chk($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
    end
    chk("wrap_last", 32'(dao), 32'd119);

    // Async reset with five entries queued and underflow set.
    do_reset();
    cyc(0, 1, '0);
    chk("async.udf_set", 32'(underflow), 32'd1);
    for (int i = 1; i <= 5; i++) cyc(1, 0, W'(i + 32));
    chk("async.count5", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 0, '0, 0, 1, 0, 0);
    #3 reset = 1'b1;
    @(negedge clk);
    chk_all("after_rst", 0, '0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
